pc_call_sequencer: RTL and testbench

//  Program-counter and call/return sequencer: the controlling end of the 16-entry, 11-bit hardware return stack.

---
 rtl/pic_pkg.sv | 26 ++
 rtl/pc_call_sequencer_if.sv | 29 ++
 rtl/stack_depth_tracker.sv | 72 +++++++
 rtl/pc_call_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_call_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and defaults for the PIC core flow-control slice.
// Provides flow_op_t, seq_state_t and PC/stack sizing defaults.
package pic_pkg;

   localparam int PC_W = 11;
   localparam int STACK_DEPTH = 16;
   localparam logic [PC_W-1:0] RESET_VECTOR = '0;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      GOTO = 3'd1,
      CALL = 3'd2,
      RET  = 3'd3,
      SKIP = 3'd4
   } flow_op_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } seq_state_t;

   function automatic int depth_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/pc_call_sequencer_if.sv
// Decoder-to-sequencer flow-op handshake bundle.
// master: op_valid/op/target/skip_cond out, op_ready in; slave mirrors.
interface pc_call_sequencer_if #(
   parameter int PC_W = pic_pkg::PC_W
);

   logic            op_valid;
   logic            op_ready;
   logic [2:0]      op;
   logic [PC_W-1:0] target;
   logic            skip_cond;

   modport master (
      output op_valid,
      output op,
      output target,
      output skip_cond,
      input  op_ready
   );

   modport slave (
      input  op_valid,
      input  op,
      input  target,
      input  skip_cond,
      output op_ready
   );

endinterface

// File: rtl/stack_depth_tracker.sv
// Return-stack occupancy counter with optional guard (STACK_GUARD_EN).
// Ports: clk, reset, inc, dec -> depth, inc_ok, dec_ok, ovf, unf.
module stack_depth_tracker #(
   parameter int STACK_DEPTH = pic_pkg::STACK_DEPTH,
   localparam int DW = $clog2(STACK_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [DW-1:0] depth,
   output logic          inc_ok,
   output logic          dec_ok,
   output logic          ovf,
   output logic          unf
);

`ifdef STACK_GUARD_EN

   logic [DW-1:0] cnt_q;
   logic          ovf_q;
   logic          unf_q;

   assign inc_ok = (cnt_q != DW'(STACK_DEPTH));
   assign dec_ok = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (inc && inc_ok)
            cnt_q <= cnt_q + 1'b1;
         else if (dec && dec_ok)
            cnt_q <= cnt_q - 1'b1;
         // sticky until reset
         if (inc && !inc_ok)
            ovf_q <= 1'b1;
         if (dec && !dec_ok)
            unf_q <= 1'b1;
      end
   end

   assign depth = cnt_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

`else

   // wraps with the stack pointer; top bit stays 0
   logic [DW-2:0] cnt_q;

   assign inc_ok = 1'b1;
   assign dec_ok = 1'b1;

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (inc)
         cnt_q <= cnt_q + 1'b1;
      else if (dec)
         cnt_q <= cnt_q - 1'b1;
   end

   assign depth = {1'b0, cnt_q};
   assign ovf   = 1'b0;
   assign unf   = 1'b0;

`endif

endmodule

// File: rtl/pc_call_sequencer.sv
// PC and call/return sequencer driving the hardware return stack.
// Ports: clk, reset, op_if (slave), stack_top -> pc, stack_in,
// push, pop, flush, depth, stk_ovf, stk_unf. Option: STACK_GUARD_EN.
module pc_call_sequencer
   import pic_pkg::*;
#(
   parameter int PC_W = pic_pkg::PC_W,
   parameter int STACK_DEPTH = pic_pkg::STACK_DEPTH,
   parameter logic [PC_W-1:0] RESET_VECTOR = pic_pkg::RESET_VECTOR,
   localparam int DW = $clog2(STACK_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   pc_call_sequencer_if.slave  op_if,
   input  logic [PC_W-1:0]     stack_top,
   output logic [PC_W-1:0]     pc,
   output logic [PC_W-1:0]     stack_in,
   output logic                push,
   output logic                pop,
   output logic                flush,
   output logic [DW-1:0]       depth,
   output logic                stk_ovf,
   output logic                stk_unf
);

   seq_state_t      state_q;
   seq_state_t      state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] stk_in_q;
   logic [PC_W-1:0] stk_in_d;
   logic            push_q;
   logic            push_d;
   logic            pop_q;
   logic            pop_d;

   logic            inc;
   logic            dec;
   logic            inc_ok;
   logic            dec_ok;

   logic            is_goto;
   logic            is_call;
   logic            is_ret;
   logic            is_skip;
   logic [PC_W-1:0] pc_inc1;
   logic [PC_W-1:0] pc_inc2;

   assign is_goto = (op_if.op == GOTO);
   assign is_call = (op_if.op == CALL);
   assign is_ret  = (op_if.op == RET);
   assign is_skip = (op_if.op == SKIP);

   assign pc_inc1 = pc_q + PC_W'(1);
   assign pc_inc2 = pc_q + PC_W'(2);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      stk_in_d = stk_in_q;
      push_d   = 1'b0;
      pop_d    = 1'b0;
      inc      = 1'b0;
      dec      = 1'b0;
      unique case (state_q)
         RUN: begin
            if (op_if.op_valid) begin
               unique case (1'b1)
                  is_goto: begin
                     pc_d    = op_if.target;
                     state_d = FLUSH;
                  end
                  is_call: begin
                     inc      = 1'b1;
                     push_d   = inc_ok;
                     stk_in_d = pc_inc1;
                     pc_d     = op_if.target;
                     state_d  = FLUSH;
                  end
                  is_ret: begin
                     dec     = 1'b1;
                     pop_d   = dec_ok;
                     // guarded underflow restarts at the vector
                     pc_d    = dec_ok ? pc_q : RESET_VECTOR;
                     state_d = FLUSH;
                  end
                  is_skip && op_if.skip_cond: begin
                     pc_d    = pc_inc2;
                     state_d = FLUSH;
                  end
                  default: begin
                     pc_d = pc_inc1;
                  end
               endcase
            end
         end
         FLUSH: begin
            state_d = RUN;
            // top is read before the pop moves the pointer
            if (pop_q)
               pc_d = stack_top;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         pc_q     <= RESET_VECTOR;
         stk_in_q <= '0;
         push_q   <= 1'b0;
         pop_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         stk_in_q <= stk_in_d;
         push_q   <= push_d;
         pop_q    <= pop_d;
      end
   end

   stack_depth_tracker #(
      .STACK_DEPTH (STACK_DEPTH)
   ) u_depth (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc),
      .dec    (dec),
      .depth  (depth),
      .inc_ok (inc_ok),
      .dec_ok (dec_ok),
      .ovf    (stk_ovf),
      .unf    (stk_unf)
   );

   assign op_if.op_ready = (state_q == RUN);
   assign flush          = (state_q == FLUSH);
   assign pc             = pc_q;
   assign stack_in       = stk_in_q;
   assign push           = push_q;
   assign pop            = pop_q;

endmodule

// File: tb/tb_pc_call_sequencer.sv
// Scoreboard bench for pc_call_sequencer with a return-stack model.
// Works with or without STACK_GUARD_EN.
module tb_pc_call_sequencer;
   import pic_pkg::*;

   localparam int DW = $clog2(STACK_DEPTH) + 1;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pc_call_sequencer_if op_if ();

   logic [PC_W-1:0] stack_top;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] stack_in;
   logic            push;
   logic            pop;
   logic            flush;
   logic [DW-1:0]   depth;
   logic            stk_ovf;
   logic            stk_unf;

   pc_call_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .op_if     (op_if),
      .stack_top (stack_top),
      .pc        (pc),
      .stack_in  (stack_in),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .depth     (depth),
      .stk_ovf   (stk_ovf),
      .stk_unf   (stk_unf)
   );

   // 16-entry wrapping return stack, pointer 15 == empty
   logic [PC_W-1:0] smem [16] = '{default: '0};
   logic [3:0]      sp = 4'd15;

   always @(posedge clk) begin
      if (reset) begin
         sp <= 4'd15;
      end else if (push) begin
         sp <= sp + 4'd1;
         smem[sp + 4'd1] <= stack_in;
      end else if (pop) begin
         sp <= sp - 4'd1;
      end
   end

   assign stack_top = smem[sp];

   typedef struct {
      logic [PC_W-1:0] pc;
      int              depth;
      bit              ovf;
      bit              unf;
      bit              bub;
   } exp_t;

   typedef struct {
      bit              is_push;
      logic [PC_W-1:0] data;
   } strb_t;

   exp_t  exp_q [$];
   strb_t strb_q [$];

   int errors = 0;
   int checks = 0;
   int push_cnt = 0;
   int pop_cnt = 0;

   // reference model: list of return addresses in a ring of 16
   logic [PC_W-1:0] m_pc = '0;
   logic [PC_W-1:0] m_ring [16] = '{default: '0};
   logic [3:0]      m_top = 4'd15;
   int              m_depth = 0;
   bit              m_ovf = 1'b0;
   bit              m_unf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_VECTOR;
      m_top = 4'd15;
      m_depth = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      op_if.op_valid = 1'b0;
      repeat (2) tick();
      exp_q.delete();
      strb_q.delete();
      model_reset();
      chk("rst_pc", pc, RESET_VECTOR);
      chk("rst_ready", op_if.op_ready, 1);
      chk("rst_push", push, 0);
      chk("rst_pop", pop, 0);
      chk("rst_flush", flush, 0);
      chk("rst_stack_in", stack_in, 0);
      chk("rst_depth", depth, 0);
      chk("rst_ovf", stk_ovf, 0);
      chk("rst_unf", stk_unf, 0);
      reset = 1'b0;
   endtask

   task automatic issue(input logic [2:0] o, input logic [PC_W-1:0] t,
                        input logic c, input bit hold);
      int   n;
      bit   bub;
      exp_t e;
      strb_t s;
      n = 0;
      while (!op_if.op_ready && n < 8) begin
         tick();
         n++;
      end
      if (!op_if.op_ready) begin
         chk("ready_timeout", op_if.op_ready, 1);
         return;
      end
      op_if.op_valid = 1'b1;
      op_if.op = o;
      op_if.target = t;
      op_if.skip_cond = c;
      bub = 1'b0;
      case (o)
         GOTO: begin
            m_pc = t;
            bub = 1'b1;
         end
         CALL: begin
            bub = 1'b1;
            if (GUARD && m_depth == STACK_DEPTH) begin
               m_ovf = 1'b1;
            end else begin
               m_top = m_top + 4'd1;
               m_ring[m_top] = m_pc + PC_W'(1);
               s.is_push = 1'b1;
               s.data = m_pc + PC_W'(1);
               strb_q.push_back(s);
               m_depth = GUARD ? m_depth + 1 : (m_depth + 1) % 16;
            end
            m_pc = t;
         end
         RET: begin
            bub = 1'b1;
            if (GUARD && m_depth == 0) begin
               m_unf = 1'b1;
               m_pc = RESET_VECTOR;
            end else begin
               m_pc = m_ring[m_top];
               m_top = m_top - 4'd1;
               s.is_push = 1'b0;
               s.data = '0;
               strb_q.push_back(s);
               m_depth = GUARD ? m_depth - 1 : (m_depth + 15) % 16;
            end
         end
         SKIP: begin
            bub = c;
            m_pc = m_pc + (c ? PC_W'(2) : PC_W'(1));
         end
         default: m_pc = m_pc + PC_W'(1);
      endcase
      e.pc = m_pc;
      e.depth = m_depth;
      e.ovf = m_ovf;
      e.unf = m_unf;
      e.bub = bub;
      exp_q.push_back(e);
      tick();
      if (hold && bub) begin
         // valid op during the bubble must be dropped
         op_if.op = GOTO;
         op_if.target = PC_W'($urandom);
         tick();
      end
      op_if.op_valid = 1'b0;
   endtask

   // monitor: pops expectations when the DUT presents results
   initial begin : monitor
      bit    wp;
      int    cyc;
      exp_t  e;
      strb_t s;
      wp = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            wp = 1'b0;
         end else begin
            chk("flush_vs_ready", flush, !op_if.op_ready);
            chk("push_pop_excl", push & pop, 0);
            if (push || pop) begin
               push_cnt += int'(push);
               pop_cnt += int'(pop);
               if (strb_q.size() == 0) begin
                  chk("strobe_unexpected", {push, pop}, 0);
               end else begin
                  s = strb_q.pop_front();
                  chk("strobe_kind", push, s.is_push);
                  if (push)
                     chk("stack_in", stack_in, s.data);
                  chk("strobe_in_flush", flush, 1);
               end
            end
            if (wp) begin
               cyc++;
               if (op_if.op_ready) begin
                  wp = 1'b0;
                  if (exp_q.size() == 0) begin
                     chk("exp_underrun", exp_q.size(), 1);
                  end else begin
                     e = exp_q.pop_front();
                     chk("pc", pc, e.pc);
                     chk("depth", depth, e.depth);
                     chk("ovf", stk_ovf, e.ovf);
                     chk("unf", stk_unf, e.unf);
                     chk("latency", cyc, e.bub ? 2 : 1);
                  end
               end else if (cyc > 2) begin
                  chk("bubble_len", cyc, 2);
                  wp = 1'b0;
               end
            end
            if (op_if.op_valid && op_if.op_ready) begin
               wp = 1'b1;
               cyc = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int c0;
      int r;
      logic [2:0] o;
      op_if.op_valid = 1'b0;
      op_if.op = NOP;
      op_if.target = '0;
      op_if.skip_cond = 1'b0;

      do_reset();
      repeat (3) issue(NOP, '0, 1'b0, 1'b0);
      tick();
      chk("nop3_pc", pc, 3);

      issue(GOTO, 11'h010, 1'b0, 1'b0);
      issue(CALL, 11'h100, 1'b0, 1'b0);
      issue(RET, '0, 1'b0, 1'b1);
      tick();
      chk("ret_pc", pc, 11'h011);
      chk("ret_depth", depth, 0);

      issue(GOTO, 11'h020, 1'b0, 1'b0);
      issue(SKIP, 11'h3AA, 1'b1, 1'b1);
      tick();
      chk("skip1_pc", pc, 11'h022);
      issue(GOTO, 11'h020, 1'b0, 1'b0);
      issue(SKIP, 11'h3AA, 1'b0, 1'b0);
      tick();
      chk("skip0_pc", pc, 11'h021);

      issue(GOTO, 11'h7FF, 1'b0, 1'b0);
      issue(NOP, '0, 1'b0, 1'b0);
      issue(GOTO, 11'h7FF, 1'b0, 1'b0);
      issue(CALL, 11'h123, 1'b0, 1'b0);
      issue(RET, '0, 1'b0, 1'b0);
      tick();
      chk("wrap_ret_pc", pc, 0);

      do_reset();
      c0 = push_cnt;
      for (int i = 0; i < 17; i++)
         issue(CALL, PC_W'($urandom), 1'b0, 1'b0);
      repeat (3) tick();
      chk("call17_pushes", push_cnt - c0, GUARD ? 16 : 17);
      chk("call17_depth", depth, GUARD ? 16 : 1);
      chk("call17_ovf", stk_ovf, GUARD);

      do_reset();
      c0 = pop_cnt;
      issue(RET, '0, 1'b0, 1'b0);
      repeat (3) tick();
      chk("ret0_pops", pop_cnt - c0, GUARD ? 0 : 1);
      chk("ret0_unf", stk_unf, GUARD);
      chk("ret0_depth", depth, GUARD ? 0 : 15);
      if (GUARD)
         chk("ret0_pc", pc, RESET_VECTOR);

      do_reset();
      issue(GOTO, 11'h040, 1'b0, 1'b0);
      issue(CALL, 11'h050, 1'b0, 1'b0);
      chk("rf_push_pending", push, 1);
      reset = 1'b1;
      tick();
      chk("rf_push", push, 0);
      chk("rf_pc", pc, 0);
      chk("rf_depth", depth, 0);
      chk("rf_ready", op_if.op_ready, 1);
      do_reset();

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1: o = NOP;
            2: o = GOTO;
            3, 4: o = CALL;
            5, 6: o = RET;
            7, 8: o = SKIP;
            default: o = 3'(5 + $urandom_range(0, 2));
         endcase
         issue(o, PC_W'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (4) tick();
      chk("exp_drain", exp_q.size(), 0);
      chk("strobe_drain", strb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
